// File: rtl/rgb_binarize_pipe.sv
// Streaming RGB -> gray -> 1-bit binarizer, 3-stage pipeline with a frame-synchronous threshold.
// Optional feature: define BIN_AUTO_THR_EN to derive the next frame's threshold from the frame mean.
module rgb_binarize_pipe #(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned KR        = 77,
  parameter int unsigned KG        = 150,
  parameter int unsigned KB        = 29,
  parameter int unsigned SHIFT     = 8,
  parameter int unsigned THR_RST   = 50,
  parameter int unsigned INVERT    = 0,
  parameter int unsigned LOG2_NPIX = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*CH_W-1:0]   in_rgb,
  input  logic                in_sof,
  input  logic                in_eof,
  input  logic [CH_W-1:0]     thr_in,
  input  logic                thr_we,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bin,
  output logic [CH_W-1:0]     out_gray,
  output logic                out_sof,
  output logic                out_eof,
  output logic [CH_W-1:0]     thr_active
);

  localparam int unsigned KMAX = (KR > KG) ? ((KR > KB) ? KR : KB) : ((KG > KB) ? KG : KB);
  localparam int unsigned PW   = CH_W + $clog2(KMAX);
  localparam int unsigned SW   = PW + 2;
  // One extra bit so adding the rounding constant cannot wrap.
  localparam int unsigned RW   = SW + 1;

  localparam logic [PW-1:0]   KrW     = PW'(KR);
  localparam logic [PW-1:0]   KgW     = PW'(KG);
  localparam logic [PW-1:0]   KbW     = PW'(KB);
  localparam logic [RW-1:0]   Rnd     = RW'(1) << (SHIFT - 1);
  localparam logic [RW-1:0]   GrayMax = {{(RW-CH_W){1'b0}}, {CH_W{1'b1}}};
  localparam logic [CH_W-1:0] ThrRst  = CH_W'(THR_RST);

  logic                v1_q, v2_q, v3_q;
  logic [PW-1:0]       pr_q, pg_q, pb_q;
  logic                sof1_q, eof1_q, sof2_q, eof2_q, sof3_q, eof3_q;
  logic [CH_W-1:0]     thr1_q, thr2_q;
  logic [CH_W-1:0]     gray2_q, gray3_q;
  logic                bin3_q;
  logic [CH_W-1:0]     thr_active_q, thr_shadow_q;

  logic                adv, accept;
  logic [CH_W-1:0]     thr_sel, thr_active_d, thr_shadow_d, gray_d;
  logic [PW-1:0]       pr_d, pg_d, pb_d;
  logic [SW-1:0]       sum;
  logic [RW-1:0]       rounded, shifted;
  logic                bin_d;

  // Global stall: every stage advances together or holds together.
  assign adv    = ~v3_q | out_ready;
  assign accept = in_valid & adv;

  always_comb begin
    pr_d = PW'(in_rgb[3*CH_W-1 -: CH_W]) * KrW;
    pg_d = PW'(in_rgb[2*CH_W-1 -: CH_W]) * KgW;
    pb_d = PW'(in_rgb[CH_W-1 -: CH_W]) * KbW;
  end

  always_comb begin
    sum     = {2'b00, pr_q} + {2'b00, pg_q} + {2'b00, pb_q};
    rounded = {1'b0, sum} + Rnd;
    shifted = rounded >> SHIFT;
    gray_d  = (shifted > GrayMax) ? {CH_W{1'b1}} : shifted[CH_W-1:0];
  end

  always_comb begin
    if (INVERT != 0) begin
      bin_d = (gray2_q < thr2_q);
    end else begin
      bin_d = (gray2_q >= thr2_q);
    end
  end

  // SOF pixel picks up the pending threshold, bypassing a same-cycle write.
  always_comb begin
    thr_sel      = thr_active_q;
    thr_active_d = thr_active_q;
    if (in_sof) begin
      thr_sel = thr_we ? thr_in : thr_shadow_q;
    end
    if (accept && in_sof) begin
      thr_active_d = thr_sel;
    end
  end

`ifdef BIN_AUTO_THR_EN
  localparam int unsigned AW = CH_W + LOG2_NPIX;

  logic [AW-1:0] acc_q, acc_sum;
  logic          out_fire;

  assign out_fire = v3_q & out_ready;

  // A transferred SOF restarts the sum with its own value.
  always_comb begin
    acc_sum = (sof3_q ? {AW{1'b0}} : acc_q) + AW'(gray3_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (out_fire) begin
      acc_q <= acc_sum;
    end
  end

  always_comb begin
    thr_shadow_d = thr_shadow_q;
    if (thr_we) begin
      thr_shadow_d = thr_in;
    end else if (out_fire && eof3_q) begin
      thr_shadow_d = acc_sum[AW-1 -: CH_W];
    end
  end
`else
  always_comb begin
    thr_shadow_d = thr_we ? thr_in : thr_shadow_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_active_q <= ThrRst;
      thr_shadow_q <= ThrRst;
    end else begin
      thr_active_q <= thr_active_d;
      thr_shadow_q <= thr_shadow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      pr_q    <= '0;
      pg_q    <= '0;
      pb_q    <= '0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
      sof2_q  <= 1'b0;
      eof2_q  <= 1'b0;
      sof3_q  <= 1'b0;
      eof3_q  <= 1'b0;
      thr1_q  <= ThrRst;
      thr2_q  <= ThrRst;
      gray2_q <= '0;
      gray3_q <= '0;
      bin3_q  <= 1'b0;
    end else if (adv) begin
      v1_q    <= in_valid;
      pr_q    <= pr_d;
      pg_q    <= pg_d;
      pb_q    <= pb_d;
      sof1_q  <= in_valid & in_sof;
      eof1_q  <= in_valid & in_eof;
      thr1_q  <= thr_sel;
      v2_q    <= v1_q;
      sof2_q  <= sof1_q;
      eof2_q  <= eof1_q;
      thr2_q  <= thr1_q;
      gray2_q <= gray_d;
      v3_q    <= v2_q;
      sof3_q  <= sof2_q;
      eof3_q  <= eof2_q;
      gray3_q <= gray2_q;
      bin3_q  <= bin_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = v3_q;
  assign out_bin    = bin3_q;
  assign out_gray   = gray3_q;
  assign out_sof    = sof3_q;
  assign out_eof    = eof3_q;
  assign thr_active = thr_active_q;

endmodule
